uart_stream_bridge: RTL
=======================

// Module: uart_stream_bridge
// PURPOSE
//   Initiator for the simpleuart CPU-side register port. Converts byte streams into reg_dat/reg_div accesses.
//   TX: valid/ready byte stream -> TX FIFO -> data-register writes, throttled by reg_dat_wait.
//   RX: polls data-register reads while RX FIFO has space -> valid/ready output stream.
//   Lets streaming logic (loaders, test generators) drive the UART without a CPU.
// PARAMETERS
//   TX_DEPTH      16   TX FIFO entries; power of 2, >= 2
//   RX_DEPTH      16   RX FIFO entries; power of 2, >= 2
//   INIT_DIVIDER  868  baud divider written to the UART once after reset (100 MHz / 115200)
// PORTS
//   clk           in   1   single clock for all logic
//   reset         in   1   synchronous, active-high
//   s_tx_valid    in   1   TX byte offered
//   s_tx_ready    out  1   TX FIFO not full
//   s_tx_data     in   8   TX byte
//   m_rx_valid    out  1   RX FIFO not empty
//   m_rx_ready    in   1   consumer takes RX head
//   m_rx_data     out  8   RX FIFO head
//   reg_div_we    out  4   divider byte enables
//   reg_div_di    out  32  divider write data
//   reg_dat_we    out  4   bit0 = send, bit2 = read
//   reg_dat_di    out  32  {24'b0, tx byte}
//   reg_dat_do    in   32  received byte in [7:0]
//   reg_dat_wait  in   1   combinational stall from UART
//   tx_level      out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
//   rx_level      out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
// BEHAVIOUR
//   Reset (sampled high at a clk edge): state=INIT, FIFOs emptied, all reg_*_we=0, reg_*_di=0,
//     s_tx_ready=0 during reset, m_rx_valid=0. Mid-operation reset discards FIFO contents and any in-flight access.
//   reg_*_we/di are decoded only from registered state/FIFO head; reg_dat_wait sampled same cycle (no comb loop).
//   FSM:
//     INIT:
//       - one cycle: reg_div_we=4'hF, reg_div_di=INIT_DIVIDER; -> IDLE. reg_div_we is 0 in all other states.
//     IDLE:
//       - TX candidate = TX FIFO non-empty; RX candidate = RX FIFO not full.
//       - Both candidates: take the one not served last (pref bit; reset value prefers TX). One candidate: take it. None: stay.
//       - IDLE drives no accesses (all we=0); one idle cycle between accesses is required.
//     TX:
//       - reg_dat_we=4'b0001, reg_dat_di={24'b0,tx_head}.
//       - wait=0: pop TX FIFO; pref<=RX; -> IDLE.
//       - wait=1: hold we/di unchanged and stay in TX.
//     RX:
//       - reg_dat_we=4'b0100, single attempt.
//       - wait=0: push reg_dat_do[7:0] into RX FIFO.
//       - wait=1: no push.
//       - Either outcome: pref<=TX; -> IDLE.
//   reg_dat_we[0] and [2] are never asserted in the same cycle.
//   FIFOs:
//     - Push/pop on valid&ready. s_tx_ready = !tx_full; m_rx_valid = !rx_empty.
//     - Simultaneous push+pop allowed; level unchanged.
//     - No pass-through when full; pointers wrap modulo depth.
//     - RX is never polled when rx_full, so no byte is lost inside the bridge.
//     - UART-side overrun is outside this block's scope.
//   Levels: tx_level/rx_level are exact registered occupancy, 0..DEPTH.
// TESTING
//   1 reset then release -> exactly one cycle reg_div_we=F, reg_div_di=868; then IDLE, s_tx_ready=1, tx_level=0
//   2 push 0x55,0xA3; wait=1 for 5 cycles on first TX -> we=1,di=0x55 held 6 cycles; then 0xA3 written; tx_level 2->0
//   3 RX model returns 0x3C with wait=0 on read -> m_rx_valid=1, m_rx_data=0x3C, rx_level=1; pops with m_rx_ready
//   4 TX FIFO nonempty and RX polls succeeding -> TX/RX accesses alternate strictly; never we=4'b0101
//   5 fill RX FIFO to 16 with m_rx_ready=0 -> no we[2] issued while full; first pop resumes polling
//   6 16 pushes with 0x10..0x1F plus a 17th while full -> s_tx_ready=0 on the 17th; assert reset mid-TX -> we=0, levels=0 next cycle

Source files
------------

// File: rtl/uart_stream_bridge_if.sv
// Byte-stream and simpleuart register-port signals of uart_stream_bridge.
// The master modport is the bridge side; slave is the stream/UART environment.
interface uart_stream_bridge_if;
  logic        s_tx_valid;
  logic        s_tx_ready;
  logic [7:0]  s_tx_data;
  logic        m_rx_valid;
  logic        m_rx_ready;
  logic [7:0]  m_rx_data;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [3:0]  reg_dat_we;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  modport master (
    input  s_tx_valid, s_tx_data, m_rx_ready, reg_dat_do, reg_dat_wait,
    output s_tx_ready, m_rx_valid, m_rx_data, reg_div_we, reg_div_di, reg_dat_we, reg_dat_di
  );

  modport slave (
    output s_tx_valid, s_tx_data, m_rx_ready, reg_dat_do, reg_dat_wait,
    input  s_tx_ready, m_rx_valid, m_rx_data, reg_div_we, reg_div_di, reg_dat_we, reg_dat_di
  );
endinterface

// File: rtl/uart_stream_bridge.sv
// Stream-to-simpleuart initiator: TX FIFO drains into data-register writes,
// RX FIFO fills from data-register polls, with fair TX/RX arbitration.
module uart_stream_bridge #(
  parameter int          TX_DEPTH     = 16,
  parameter int          RX_DEPTH     = 16,
  parameter logic [31:0] INIT_DIVIDER = 32'd868
) (
  input  logic                      clk,
  input  logic                      reset,
  uart_stream_bridge_if.master      bus,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_LVL = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_LVL = (RX_AW + 1)'(RX_DEPTH);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_TX, ST_RX} state_t;

  state_t           state, state_nxt;
  logic             pref_rx, pref_rx_nxt;
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic             tx_full, rx_full, tx_cand, rx_cand;
  logic             tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full = (tx_level == TX_FULL_LVL);
  assign rx_full = (rx_level == RX_FULL_LVL);
  assign tx_cand = (tx_level != '0);
  assign rx_cand = !rx_full;

  assign bus.s_tx_ready = !reset && !tx_full;
  assign bus.m_rx_valid = (rx_level != '0);
  assign bus.m_rx_data  = rx_mem[rx_rd_ptr];

  assign tx_push = bus.s_tx_valid && bus.s_tx_ready;
  assign tx_pop  = (state == ST_TX) && !bus.reg_dat_wait;
  assign rx_push = (state == ST_RX) && !bus.reg_dat_wait;
  assign rx_pop  = bus.m_rx_valid && bus.m_rx_ready;

  always_comb begin
    state_nxt       = state;
    pref_rx_nxt     = pref_rx;
    bus.reg_div_we  = 4'h0;
    bus.reg_div_di  = 32'h0;
    bus.reg_dat_we  = 4'h0;
    bus.reg_dat_di  = 32'h0;
    case (state)
      ST_INIT: begin
        bus.reg_div_we = 4'hF;
        bus.reg_div_di = INIT_DIVIDER;
        state_nxt      = ST_IDLE;
      end
      ST_IDLE: begin
        // Contention goes to whichever side was not served last.
        if (tx_cand && rx_cand) state_nxt = pref_rx ? ST_RX : ST_TX;
        else if (tx_cand)       state_nxt = ST_TX;
        else if (rx_cand)       state_nxt = ST_RX;
      end
      ST_TX: begin
        bus.reg_dat_we = 4'b0001;
        bus.reg_dat_di = {24'h0, tx_mem[tx_rd_ptr]};
        if (!bus.reg_dat_wait) begin
          pref_rx_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_RX: begin
        // A stalled poll is simply abandoned; the next one retries.
        bus.reg_dat_we = 4'b0100;
        pref_rx_nxt    = 1'b0;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
    if (reset) begin
      bus.reg_div_we = 4'h0;
      bus.reg_div_di = 32'h0;
      bus.reg_dat_we = 4'h0;
      bus.reg_dat_di = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      pref_rx   <= 1'b0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      tx_level  <= '0;
      rx_level  <= '0;
    end else begin
      state   <= state_nxt;
      pref_rx <= pref_rx_nxt;
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + 1'b1;
        2'b01:   tx_level <= tx_level - 1'b1;
        default: tx_level <= tx_level;
      endcase
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + 1'b1;
        2'b01:   rx_level <= rx_level - 1'b1;
        default: rx_level <= rx_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.s_tx_data;
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.reg_dat_do[7:0];
  end
endmodule
